// File: rtl/fpu_dispatch.sv
// rtl/fpu_dispatch.sv - single-issue request dispatcher between core and sfpu, with writeback handshake.
// Optional FPU_DISPATCH_SKID_EN adds a one-entry request buffer so a request can be accepted while busy.
module fpu_dispatch (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic        req_unsigned,
  input  logic [2:0]  req_rm,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_rs3,
  input  logic [31:0] req_int,
  input  logic [2:0]  csr_frm,
  input  logic        fflags_clr,
  output logic [4:0]  fflags,
  output logic [31:0] fpu_operand_a,
  output logic [31:0] fpu_operand_b,
  output logic [31:0] fpu_operand_c,
  output logic [31:0] fpu_operand_int,
  output logic [2:0]  fpu_frm,
  output logic [23:0] fpu_sfpu_op,
  output logic [27:0] fpu_vfpu_op,
  output logic [2:0]  fpu_sel,
  input  logic [31:0] fpu_resultant,
  input  logic [31:0] fpu_result_rd,
  input  logic [4:0]  fpu_s_flags,
  input  logic        fpu_exception_flag,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_to_int
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WB} state_t;

  typedef struct packed {
    logic [4:0]  op;
    logic        is_unsigned;
    logic [2:0]  rm;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rs3;
    logic [31:0] ival;
  } req_t;

  function automatic logic is_legal(input req_t r);
    return (r.op <= 5'd2 || (r.op >= 5'd5 && r.op <= 5'd21)) && r.rm != 3'd5 && r.rm != 3'd6;
  endfunction

  function automatic logic dest_is_int(input logic [4:0] op);
    case (op)
      5'd7, 5'd9, 5'd10, 5'd11, 5'd14, 5'd21: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  state_t state, state_next;
  req_t   req_in, launch_req, cur;
  logic   ready_en, req_fire, launch, launch_legal;
  logic   [4:0] flags_base;
  logic   unused_exception;

  assign unused_exception = fpu_exception_flag;

  assign req_in = '{op: req_op, is_unsigned: req_unsigned, rm: req_rm, rd: req_rd,
                    rs1: req_rs1, rs2: req_rs2, rs3: req_rs3, ival: req_int};

`ifdef FPU_DISPATCH_SKID_EN
  req_t buf_req;
  logic buf_full, push, pop;
  assign req_ready = ready_en && !buf_full;
`else
  assign req_ready = ready_en && (state == IDLE);
`endif

  assign req_fire     = req_valid && req_ready;
  assign launch_legal = is_legal(launch_req);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    launch_req = req_in;
`ifdef FPU_DISPATCH_SKID_EN
    push = req_fire;
    pop  = 1'b0;
`endif
    case (state)
      IDLE: begin
        launch = req_fire;
`ifdef FPU_DISPATCH_SKID_EN
        push = 1'b0;
`endif
      end
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = WB;
      WB: begin
        if (wb_ready) begin
          state_next = IDLE;
`ifdef FPU_DISPATCH_SKID_EN
          // A buffered request is older than anything arriving now, so it goes first.
          if (buf_full) begin
            pop        = 1'b1;
            launch     = 1'b1;
            launch_req = buf_req;
          end else begin
            launch = req_fire;
            push   = 1'b0;
          end
`endif
        end
      end
      default: state_next = IDLE;
    endcase
    if (launch) state_next = launch_legal ? ISSUE : WB;
  end

`ifdef FPU_DISPATCH_SKID_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      buf_full <= 1'b0;
      buf_req  <= '0;
    end else begin
      if (pop) buf_full <= 1'b0;
      if (push) begin
        buf_full <= 1'b1;
        buf_req  <= req_in;
      end
    end
  end
`endif

  assign flags_base = fflags_clr ? 5'd0 : fflags;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ready_en  <= 1'b0;
      cur       <= '0;
      wb_data   <= '0;
      wb_to_int <= 1'b0;
      fflags    <= '0;
    end else begin
      ready_en <= 1'b1;
      if (launch) begin
        cur       <= launch_req;
        wb_data   <= '0;
        wb_to_int <= launch_legal && dest_is_int(launch_req.op);
      end else if (state == CAPTURE) begin
        wb_data <= wb_to_int ? fpu_result_rd : fpu_resultant;
      end
      if (state == CAPTURE)            fflags <= flags_base | fpu_s_flags;
      else if (launch && !launch_legal) fflags <= flags_base | 5'b10000;
      else                             fflags <= flags_base;
    end
  end

  always_comb begin
    fpu_sfpu_op = '0;
    if (state == ISSUE) begin
      fpu_sfpu_op = 24'd1 << cur.op;
      if (cur.op == 5'd14 || cur.op == 5'd15)
        fpu_sfpu_op = fpu_sfpu_op | (cur.is_unsigned ? 24'h400000 : 24'h800000);
    end
  end

  assign fpu_operand_a   = cur.rs1;
  assign fpu_operand_b   = cur.rs2;
  assign fpu_operand_c   = cur.rs3;
  assign fpu_operand_int = cur.ival;
  assign fpu_frm         = (cur.rm == 3'b111) ? csr_frm : cur.rm;
  assign fpu_vfpu_op     = '0;
  assign fpu_sel         = '0;
  assign wb_valid        = (state == WB);
  assign wb_rd           = cur.rd;

endmodule

// File: tb/tb_fpu_dispatch.sv
// tb/tb_fpu_dispatch.sv - randomized self-checking bench for fpu_dispatch with a stub FPU.
// Stub FPU registers a result one cycle after seeing a nonzero opcode and outputs zero otherwise.
module tb_fpu_dispatch;
  logic        clk = 1'b0;
  logic        rst_l;
  logic        req_valid, req_ready, req_unsigned, fflags_clr, wb_valid, wb_ready, wb_to_int;
  logic [4:0]  req_op, req_rd, fflags, wb_rd, fpu_s_flags;
  logic [2:0]  req_rm, csr_frm, fpu_frm, fpu_sel;
  logic [31:0] req_rs1, req_rs2, req_rs3, req_int, wb_data;
  logic [31:0] fpu_operand_a, fpu_operand_b, fpu_operand_c, fpu_operand_int;
  logic [31:0] fpu_resultant, fpu_result_rd;
  logic [23:0] fpu_sfpu_op;
  logic [27:0] fpu_vfpu_op;
  logic        fpu_exception_flag;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] model_flags = 5'd0;

  fpu_dispatch dut (
    .clk(clk), .rst_l(rst_l), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_unsigned(req_unsigned), .req_rm(req_rm), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .req_int(req_int),
    .csr_frm(csr_frm), .fflags_clr(fflags_clr), .fflags(fflags),
    .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b), .fpu_operand_c(fpu_operand_c),
    .fpu_operand_int(fpu_operand_int), .fpu_frm(fpu_frm), .fpu_sfpu_op(fpu_sfpu_op),
    .fpu_vfpu_op(fpu_vfpu_op), .fpu_sel(fpu_sel), .fpu_resultant(fpu_resultant),
    .fpu_result_rd(fpu_result_rd), .fpu_s_flags(fpu_s_flags),
    .fpu_exception_flag(fpu_exception_flag), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_to_int(wb_to_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stub results: exact for the known vectors, otherwise a deterministic mix of the inputs.
  function automatic logic [31:0] stub_res(input logic [23:0] sop, input logic [31:0] a, b, c, iv);
    if (sop[0] && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (sop[15] && sop[23] && iv == 32'hFFFFFFFF) return 32'hBF800000;
    return a ^ {b[15:0], b[31:16]} ^ (c * 3) ^ {8'h0, sop};
  endfunction

  function automatic logic [31:0] stub_rd(input logic [23:0] sop, input logic [31:0] a, b, iv);
    if (sop[10]) return {31'd0, a < b};  // flt, exact for positive operands
    return (a + iv) ^ {8'h0, sop};
  endfunction

  function automatic logic [4:0] stub_flags(input logic [31:0] a, b);
    if (a == 32'h7F800001) return 5'b10000;
    return a[4:0] ^ b[9:5];
  endfunction

  always @(posedge clk) begin
    if (fpu_sfpu_op != 24'd0) begin
      fpu_resultant <= stub_res(fpu_sfpu_op, fpu_operand_a, fpu_operand_b, fpu_operand_c, fpu_operand_int);
      fpu_result_rd <= stub_rd(fpu_sfpu_op, fpu_operand_a, fpu_operand_b, fpu_operand_int);
      fpu_s_flags   <= stub_flags(fpu_operand_a, fpu_operand_b);
      fpu_exception_flag <= fpu_operand_a[0];
    end else begin
      fpu_resultant <= '0;
      fpu_result_rd <= '0;
      fpu_s_flags   <= '0;
      fpu_exception_flag <= 1'b0;
    end
  end

  function automatic bit ref_legal(input int op, input int rm);
    return !(op == 3 || op == 4 || op > 21 || rm == 5 || rm == 6);
  endfunction

  function automatic bit ref_to_int(input int op);
    return op == 7 || op == 9 || op == 10 || op == 11 || op == 14 || op == 21;
  endfunction

  function automatic logic [23:0] ref_sop(input int op, input bit uns);
    int v;
    v = 1 << op;
    if (op == 14 || op == 15) v = v + (uns ? (1 << 22) : (1 << 23));
    return v[23:0];
  endfunction

  task automatic run_op(input int op, input bit uns, input int rm, input logic [4:0] rd,
                        input logic [31:0] a, b, c, iv, input int hold, input bit clr_cap,
                        input bit rst_cap, output logic [31:0] got_data, output logic [23:0] got_sop);
    bit legal, tint;
    logic [23:0] esop;
    logic [31:0] edata, held;
    logic [2:0] efrm;
    int lat, pulses, waitc, seen;
    legal = ref_legal(op, rm);
    tint  = legal && ref_to_int(op);
    esop  = legal ? ref_sop(op, uns) : 24'd0;
    efrm  = (rm == 7) ? csr_frm : 3'(rm);
    edata = !legal ? 32'd0 : tint ? stub_rd(esop, a, b, iv) : stub_res(esop, a, b, c, iv);
    got_data = '0;
    got_sop  = '0;
    req_op = 5'(op); req_unsigned = uns; req_rm = 3'(rm); req_rd = rd;
    req_rs1 = a; req_rs2 = b; req_rs3 = c; req_int = iv; req_valid = 1'b1;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    check("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; pulses = 0;
    while (!wb_valid && lat < 10) begin
      if (fpu_sfpu_op != 24'd0) begin
        pulses++;
        got_sop = fpu_sfpu_op;
      end
      if (lat == 0 && legal) begin
        check("issue_sop", 32'(fpu_sfpu_op), 32'(esop));
        check("issue_a", fpu_operand_a, a);
        check("issue_b", fpu_operand_b, b);
        check("issue_c", fpu_operand_c, c);
        check("issue_int", fpu_operand_int, iv);
        check("issue_frm", 32'(fpu_frm), 32'(efrm));
      end
      if (lat == 1 && clr_cap) fflags_clr = 1'b1;
      if (lat == 1 && rst_cap) begin
        rst_l = 1'b0;
        #2;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_fflags", 32'(fflags), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_operand_a", fpu_operand_a, 32'd0);
        check("rst_sop", 32'(fpu_sfpu_op), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_l = 1'b1;
        model_flags = 5'd0;
        @(posedge clk); #1;
        check("rst_ready_back", 32'(req_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
          if (wb_valid) seen++;
          @(posedge clk); #1;
        end
        check("rst_no_wb", 32'(seen), 32'd0);
        return;
      end
      @(posedge clk); #1;
      fflags_clr = 1'b0;
      lat++;
    end
    check("wb_latency", 32'(lat), legal ? 32'd2 : 32'd0);
    check("sop_pulses", 32'(pulses), legal ? 32'd1 : 32'd0);
    if (!legal) model_flags = model_flags | 5'b10000;
    else        model_flags = (clr_cap ? 5'd0 : model_flags) | stub_flags(a, b);
    held = wb_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("wb_hold_data", wb_data, held);
      check("wb_hold_valid", 32'(wb_valid), 32'd1);
    end
    check("wb_data", wb_data, edata);
    check("wb_to_int", 32'(wb_to_int), 32'(tint));
    check("wb_rd", 32'(wb_rd), 32'(rd));
    check("fflags", 32'(fflags), 32'(model_flags));
    got_data = wb_data;
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    check("wb_release", 32'(wb_valid), 32'd0);
  endtask

  logic [31:0] d;
  logic [23:0] s;

  initial begin
    rst_l = 1'b0; req_valid = 1'b0; wb_ready = 1'b0; fflags_clr = 1'b0;
    req_op = '0; req_unsigned = 1'b0; req_rm = '0; req_rd = '0;
    req_rs1 = '0; req_rs2 = '0; req_rs3 = '0; req_int = '0; csr_frm = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_wb_valid", 32'(wb_valid), 32'd0);
    check("reset_fflags", 32'(fflags), 32'd0);
    check("reset_sop", 32'(fpu_sfpu_op), 32'd0);
    check("reset_wb_data", wb_data, 32'd0);
    check("reset_wb_rd", 32'(wb_rd), 32'd0);
    check("reset_wb_to_int", 32'(wb_to_int), 32'd0);
    check("reset_operand_a", fpu_operand_a, 32'd0);
    rst_l = 1'b1;
    @(posedge clk); #1;

    run_op(0, 0, 0, 5'd3, 32'h3F800000, 32'h40000000, 32'd0, 32'd0, 0, 0, 0, d, s);
    check("fadd_result", d, 32'h40400000);
    check("fadd_fflags", 32'(fflags), 32'd0);
    run_op(10, 0, 0, 5'd4, 32'h3F800000, 32'h40000000, 32'd0, 32'd0, 1, 0, 0, d, s);
    check("flt_result", d, 32'h00000001);
    run_op(15, 0, 0, 5'd5, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 0, 0, 0, d, s);
    check("fcvt_sop", 32'(s), 32'h00808000);
    check("fcvt_result", d, 32'hBF800000);
    run_op(0, 0, 0, 5'd6, 32'h7F800001, 32'h40000000, 32'd0, 32'd0, 0, 0, 0, d, s);
    check("snan_fflags", 32'(fflags), 32'h10);
    run_op(0, 0, 0, 5'd7, 32'h3F800000, 32'h40000000, 32'd0, 32'd0, 0, 1, 0, d, s);
    check("clr_fflags", 32'(fflags), 32'd0);
    run_op(3, 0, 0, 5'd8, 32'h12345678, 32'h1, 32'd0, 32'd0, 4, 0, 0, d, s);
    check("illegal_op_data", d, 32'd0);
    check("illegal_op_fflags", 32'(fflags), 32'h10);
    run_op(1, 0, 5, 5'd9, 32'h12345678, 32'h1, 32'd0, 32'd0, 4, 0, 0, d, s);
    check("illegal_rm_data", d, 32'd0);
    check("illegal_rm_fflags", 32'(fflags), 32'h10);
    csr_frm = 3'd4;
    run_op(14, 1, 7, 5'd10, 32'h40A00000, 32'd0, 32'd0, 32'd0, 0, 0, 0, d, s);
    run_op(2, 0, 0, 5'd11, 32'h11111111, 32'h22222222, 32'h3, 32'h4, 0, 0, 1, d, s);

    for (int i = 0; i < 40; i++) begin
      csr_frm = 3'($urandom_range(0, 7));
      run_op($urandom_range(0, 31), 1'($urandom), $urandom_range(0, 7), 5'($urandom),
             $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3),
             ($urandom_range(0, 7) == 0), 0, d, s);
    end

`ifdef FPU_DISPATCH_SKID_EN
    begin
      int cnt;
      logic [4:0] order [2];
      order[0] = '0; order[1] = '0;
      req_op = 5'd0; req_rm = 3'd0; req_rs1 = 32'h3F800000; req_rs2 = 32'h40000000;
      req_rd = 5'd1; req_valid = 1'b1;
      @(posedge clk); #1;
      req_rd = 5'd2;
      check("skid_ready_busy", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      wb_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
        if (wb_valid && cnt < 2) begin
          order[cnt] = wb_rd;
          cnt++;
        end
        @(posedge clk); #1;
      end
      wb_ready = 1'b0;
      check("skid_count", 32'(cnt), 32'd2);
      check("skid_first", 32'(order[0]), 32'd1);
      check("skid_second", 32'(order[1]), 32'd2);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
